// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, pointer types and FSM encoding
// for the 5x5 convolution window front end.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int IMG_W = 512;
  localparam int KSZ   = 5;
  localparam int NBUF  = KSZ + 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int CNT_W = 12;
  localparam int SEL_W = $clog2(NBUF);
  localparam int WIN_W = KSZ * KSZ * PIX_W;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic sel_t sel_inc(input sel_t s);
    return (s == sel_t'(NBUF - 1)) ? '0 : s + sel_t'(1);
  endfunction

  // (s + r) mod NBUF for r < NBUF
  function automatic sel_t sel_add(input sel_t s, input int r);
    int t;
    t = int'(s) + r;
    if (t >= NBUF) t = t - NBUF;
    return sel_t'(t);
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: pixel stream in, window handshake out, line-retire irq.
// master drives pixels/ready, slave (the controller) drives full/window/valid/intr.
interface conv_window_ctrl_if;
  import conv_pkg::*;

  logic [PIX_W-1:0] i_pixel_data;
  logic             i_pixel_data_valid;
  logic             o_full;
  logic [WIN_W-1:0] o_window;
  logic             o_window_valid;
  logic             i_window_ready;
  logic             o_intr;

  modport master (
    output i_pixel_data, i_pixel_data_valid, i_window_ready,
    input  o_full, o_window, o_window_valid, o_intr
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid, i_window_ready,
    output o_full, o_window, o_window_valid, o_intr
  );

endinterface

// File: rtl/conv_line_store.sv
// conv_line_store: one IMG_W x PIX_W line, one write port, KSZ-tap comb read.
// Ports: i_clk, i_we/i_wr_col/i_wr_data write, i_rd_col -> o_taps[c] = line[rd+c].
module conv_line_store
  import conv_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_we,
  input  col_t                       i_wr_col,
  input  logic [PIX_W-1:0]           i_wr_data,
  input  col_t                       i_rd_col,
  output logic [KSZ-1:0][PIX_W-1:0]  o_taps
);

  logic [PIX_W-1:0] r_mem [IMG_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_col] <= i_wr_data;
  end

  always_comb begin
    o_taps = '0;
    for (int c = 0; c < KSZ; c++) begin
      o_taps[c] = r_mem[i_rd_col + col_t'(c)];
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: rotates raster lines over NBUF stores, emits KSZxKSZ windows.
// Ports: i_clk, i_rst (sync, high), bus (slave): pixels in, window/valid/ready, full, intr.
module conv_window_ctrl
  import conv_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  conv_window_ctrl_if.slave  bus
);

  col_t   r_wr_col;
  col_t   r_rd_col;
  sel_t   r_wr_sel;
  sel_t   r_rd_sel;
  cnt_t   r_cnt;
  state_t r_state;
  logic   r_intr;

  state_t w_state_nxt;
  cnt_t   w_cnt_nxt;
  logic   w_full;
  logic   w_wr;
  logic   w_hs;
  logic   w_retire;
  sel_t   w_row_sel [KSZ];
  logic [WIN_W-1:0] w_window;
  logic [KSZ-1:0][PIX_W-1:0] w_taps [NBUF];

  assign w_full   = (r_cnt == cnt_t'(NBUF * IMG_W));
  assign w_wr     = bus.i_pixel_data_valid & ~w_full;
  assign w_hs     = (r_state == READ) & bus.i_window_ready;
  assign w_retire = w_hs & (r_rd_col == col_t'(IMG_W - KSZ));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr)     w_cnt_nxt = w_cnt_nxt + cnt_t'(1);
    if (w_retire) w_cnt_nxt = w_cnt_nxt - cnt_t'(IMG_W);
  end

  // Look at the post-edge count so valid rises right after the
  // edge that stores the last pixel of the KSZ-th line.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_cnt_nxt >= cnt_t'(KSZ * IMG_W)) w_state_nxt = READ;
      READ: if (w_retire) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_intr   <= 1'b0;
      r_wr_col <= '0;
      r_wr_sel <= '0;
      r_rd_col <= '0;
      r_rd_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_intr  <= w_retire;
      if (w_wr) begin
        if (r_wr_col == col_t'(IMG_W - 1)) begin
          r_wr_col <= '0;
          r_wr_sel <= sel_inc(r_wr_sel);
        end else begin
          r_wr_col <= r_wr_col + col_t'(1);
        end
      end
      if (w_hs) begin
        if (w_retire) begin
          r_rd_col <= '0;
          r_rd_sel <= sel_inc(r_rd_sel);
        end else begin
          r_rd_col <= r_rd_col + col_t'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_store
    conv_line_store u_store (
      .i_clk     (i_clk),
      .i_we      (w_wr && (r_wr_sel == sel_t'(b))),
      .i_wr_col  (r_wr_col),
      .i_wr_data (bus.i_pixel_data),
      .i_rd_col  (r_rd_col),
      .o_taps    (w_taps[b])
    );
  end

  always_comb begin
    for (int r = 0; r < KSZ; r++) begin
      w_row_sel[r] = sel_add(r_rd_sel, r);
    end
  end

  // row 0 / col 0 lands in the MSBs, row-major
  always_comb begin
    w_window = '0;
    for (int r = 0; r < KSZ; r++) begin
      for (int c = 0; c < KSZ; c++) begin
        w_window[(KSZ*KSZ-1-(r*KSZ+c))*PIX_W +: PIX_W] =
          w_taps[w_row_sel[r]][c];
      end
    end
  end

  assign bus.o_window       = w_window;
  assign bus.o_window_valid = (r_state == READ);
  assign bus.o_full         = w_full;
  assign bus.o_intr         = r_intr;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: scoreboard bench for conv_window_ctrl.
// Expected windows are queued as lines complete and popped on each handshake.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  conv_window_ctrl_if bus ();

  conv_window_ctrl dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [WIN_W-1:0] got,
                     input logic [WIN_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]       mline [16][IMG_W];
  logic [WIN_W-1:0] sb [$];

  bit m_live = 0;
  bit m_read = 0;
  bit m_intr = 0;
  int m_cnt  = 0;
  int m_wline = 0;
  int m_wcol = 0;
  int m_rcol = 0;

  function automatic logic [WIN_W-1:0] exp_win(input int base, input int col);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < KSZ; r++)
      for (int c = 0; c < KSZ; c++)
        w[(KSZ*KSZ-1-(r*KSZ+c))*PIX_W +: PIX_W] = mline[(base+r)%16][col+c];
    return w;
  endfunction

  // Model state describes the DUT after the coming posedge;
  // inputs are stable here because the driver moves them #1 after posedge.
  always @(negedge i_clk) begin : mdl
    bit acc;
    bit hs;
    bit ret;
    if (m_live) begin
      chk("full", WIN_W'(bus.o_full), WIN_W'(m_cnt == NBUF*IMG_W));
      chk("valid", WIN_W'(bus.o_window_valid), WIN_W'(m_read));
      chk("intr", WIN_W'(bus.o_intr), WIN_W'(m_intr));
      if (m_read) begin
        if (sb.size() == 0)
          chk("sb_empty", WIN_W'(sb.size()), WIN_W'(1));
        else if (bus.i_window_ready && !i_rst)
          chk("win", bus.o_window, sb.pop_front());
        else
          chk("hold", bus.o_window, sb[0]);
      end
    end
    if (i_rst) begin
      m_live = 1; m_read = 0; m_intr = 0; m_cnt = 0;
      m_wline = 0; m_wcol = 0; m_rcol = 0;
      sb.delete();
    end else if (m_live) begin
      acc = bus.i_pixel_data_valid && (m_cnt != NBUF*IMG_W);
      hs  = m_read && bus.i_window_ready;
      ret = hs && (m_rcol == IMG_W-KSZ);
      if (acc) begin
        mline[m_wline%16][m_wcol] = bus.i_pixel_data;
        m_wcol++;
        if (m_wcol == IMG_W) begin
          m_wcol = 0;
          m_wline++;
          if (m_wline >= KSZ)
            for (int c = 0; c <= IMG_W-KSZ; c++)
              sb.push_back(exp_win(m_wline-KSZ, c));
        end
      end
      m_cnt = m_cnt + (acc ? 1 : 0) - (ret ? IMG_W : 0);
      if (hs) m_rcol = ret ? 0 : m_rcol + 1;
      m_intr = ret;
      if (!m_read) m_read = (m_cnt >= KSZ*IMG_W);
      else if (ret) m_read = 0;
    end
  end

  task automatic cyc(input logic rst, input logic pv,
                     input logic [7:0] pd, input logic rdy);
    @(posedge i_clk);
    #1;
    i_rst = rst;
    bus.i_pixel_data_valid = pv;
    bus.i_pixel_data = pd;
    bus.i_window_ready = rdy;
  endtask

  initial begin
    bus.i_pixel_data_valid = 1'b1;
    bus.i_pixel_data = 8'hAA;
    bus.i_window_ready = 1'b0;

    // reset held with valid high: nothing may land
    repeat (3) cyc(1, 1, 8'hAA, 0);

    // fill 5 lines, ready high, then backpressure at col 100
    for (int i = 0; i < KSZ*IMG_W; i++) cyc(0, 1, 8'(i), 1);
    repeat (100) cyc(0, 0, 8'h00, 1);
    repeat (3) cyc(0, 0, 8'h00, 0);
    repeat (520) cyc(0, 0, 8'h00, 1);
    @(negedge i_clk);
    chk("sb_drain1", WIN_W'(sb.size()), '0);

    // full / drop, then simultaneous write and retire
    repeat (3) cyc(1, 1, 8'h11, 0);
    for (int i = 0; i < NBUF*IMG_W; i++) cyc(0, 1, 8'(i*7), 0);
    cyc(0, 1, 8'hAA, 0);
    repeat (IMG_W-KSZ+1) cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < IMG_W-1; i++) cyc(0, 1, 8'(i*3+1), 0);
    repeat (IMG_W-KSZ) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'hC3, 1);
    repeat (520) cyc(0, 0, 8'h00, 1);
    @(negedge i_clk);
    chk("sb_drain2", WIN_W'(sb.size()), '0);

    // reset in the middle of a READ line, refill with 0x55
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < KSZ*IMG_W; i++) cyc(0, 1, 8'(i), 0);
    repeat (250) cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    for (int i = 0; i < KSZ*IMG_W; i++) cyc(0, 1, 8'h55, 0);
    repeat (5) cyc(0, 0, 8'h00, 1);
    @(negedge i_clk);
    chk("win55", bus.o_window, {25{8'h55}});

    cyc(0, 0, 8'h00, 0);
    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
